// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use and long-op scoreboard with stall/bubble generation and IP watchdog
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             use1_ID,
  input  logic             use2_ID,
  input  logic [4:0]       dst_ID,
  input  logic             RegWrite_ID,
  input  logic             LongOp_ID,
  input  logic             valid_ID,
  input  logic             FLUSH,
  input  logic [4:0]       dst_EX,
  input  logic             MemRead_EX,
  input  logic             RegWrite_EX,
  input  logic             ip_done,
  input  logic [4:0]       ip_dst,
  output logic             stall,
  output logic             bubble_EX,
  output logic             ip_start,
  output logic             ip_busy,
  output logic [NREG-1:0]  busy_vec,
  output logic             ip_timeout,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            load_use, sb_haz, issue, done, tmo;
  logic [NREG-1:0] busy_nxt;
  // hazard detection, issue control and next scoreboard contents
  always_comb begin
    load_use  = MemRead_EX & RegWrite_EX & (dst_EX != 5'd0) &
                ((use1_ID & (src1_ID == dst_EX)) | (use2_ID & (src2_ID == dst_EX)));
    sb_haz    = (use1_ID & (src1_ID != 5'd0) & busy_vec[src1_ID]) |
                (use2_ID & (src2_ID != 5'd0) & busy_vec[src2_ID]) |
                (RegWrite_ID & (dst_ID != 5'd0) & busy_vec[dst_ID]);
    stall     = valid_ID & ~FLUSH & (load_use | sb_haz | (LongOp_ID & ip_busy));
    bubble_EX = stall | FLUSH;
    issue     = valid_ID & ~FLUSH & ~stall;
    ip_start  = issue & LongOp_ID;
    done      = ip_done & ip_busy;
    tmo       = ip_busy & ~ip_done & (wd == WD_W'(TIMEOUT - 1));
    busy_nxt  = busy_vec;
    if (done) busy_nxt[ip_dst] = 1'b0;
    if (ip_start & RegWrite_ID) busy_nxt[dst_ID] = 1'b1;
    if (tmo) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  // scoreboard, in-flight tracking, watchdog and stall statistics
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      busy_vec   <= '0;
      ip_busy    <= 1'b0;
      ip_timeout <= 1'b0;
      stall_cnt  <= '0;
      wd         <= '0;
    end else begin
      busy_vec   <= busy_nxt;
      ip_busy    <= ip_start ? 1'b1 : (done | tmo) ? 1'b0 : ip_busy;
      wd         <= ip_start ? '0 : ip_busy ? wd + 1'b1 : wd;
      ip_timeout <= ip_timeout | tmo;
      if (stall & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized check of hazard_scoreboard against a register-set reference model
module tb_hazard_scoreboard;
  localparam int TMO = 8;
  localparam int CW  = 4;
  logic          CLK = 0, RSTN;
  logic [4:0]    src1_ID, src2_ID, dst_ID, dst_EX, ip_dst;
  logic          use1_ID, use2_ID, RegWrite_ID, LongOp_ID, valid_ID, FLUSH;
  logic          MemRead_EX, RegWrite_EX, ip_done;
  logic          stall, bubble_EX, ip_start, ip_busy, ip_timeout;
  logic [31:0]   busy_vec;
  logic [CW-1:0] stall_cnt;
  int            checks = 0, errors = 0;
  bit            pend[32];
  bit            m_busy, m_tmo;
  int            age, m_cnt, ld;

  hazard_scoreboard #(.NREG(32), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .CLK(CLK), .RSTN(RSTN), .src1_ID(src1_ID), .src2_ID(src2_ID), .use1_ID(use1_ID),
    .use2_ID(use2_ID), .dst_ID(dst_ID), .RegWrite_ID(RegWrite_ID), .LongOp_ID(LongOp_ID),
    .valid_ID(valid_ID), .FLUSH(FLUSH), .dst_EX(dst_EX), .MemRead_EX(MemRead_EX),
    .RegWrite_EX(RegWrite_EX), .ip_done(ip_done), .ip_dst(ip_dst), .stall(stall),
    .bubble_EX(bubble_EX), .ip_start(ip_start), .ip_busy(ip_busy), .busy_vec(busy_vec),
    .ip_timeout(ip_timeout), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive();
    RSTN        = ($urandom_range(0, 299) != 0);
    valid_ID    = ($urandom_range(0, 9) != 0);
    FLUSH       = ($urandom_range(0, 9) == 0);
    src1_ID     = 5'($urandom_range(0, 7));
    src2_ID     = 5'($urandom_range(0, 7));
    dst_ID      = 5'($urandom_range(0, 7));
    use1_ID     = ($urandom_range(0, 3) != 0);
    use2_ID     = ($urandom_range(0, 3) != 0);
    RegWrite_ID = ($urandom_range(0, 4) != 0);
    LongOp_ID   = ($urandom_range(0, 9) < 3);
    dst_EX      = 5'($urandom_range(0, 7));
    MemRead_EX  = ($urandom_range(0, 9) < 3);
    RegWrite_EX = ($urandom_range(0, 9) != 0);
    ip_done     = m_busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) == 0);
    ip_dst      = ($urandom_range(0, 7) != 0) ? 5'(ld) : 5'($urandom_range(0, 7));
  endtask

  initial begin
    bit lu, sb, e_stall, e_start;
    logic [31:0] ev;
    m_busy = 0; m_tmo = 0; age = 0; m_cnt = 0; ld = 0;
    foreach (pend[i]) pend[i] = 0;
    drive();
    RSTN = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("reset_busy_vec", busy_vec, 0);
    check("reset_ip_busy", ip_busy, 0);
    check("reset_timeout", ip_timeout, 0);
    check("reset_stall_cnt", stall_cnt, 0);
    @(posedge CLK); #1;
    for (int c = 0; c < 6000; c++) begin
      drive();
      @(negedge CLK);
      lu = MemRead_EX && RegWrite_EX && dst_EX != 0 &&
           ((use1_ID && src1_ID == dst_EX) || (use2_ID && src2_ID == dst_EX));
      sb = (use1_ID && src1_ID != 0 && pend[src1_ID]) ||
           (use2_ID && src2_ID != 0 && pend[src2_ID]) ||
           (RegWrite_ID && dst_ID != 0 && pend[dst_ID]);
      e_stall = valid_ID && !FLUSH && (lu || sb || (LongOp_ID && m_busy));
      e_start = valid_ID && !FLUSH && !e_stall && LongOp_ID;
      ev = 0;
      for (int r = 1; r < 32; r++) ev[r] = pend[r];
      check("stall", stall, e_stall);
      check("bubble_EX", bubble_EX, e_stall || FLUSH);
      check("ip_start", ip_start, e_start);
      check("ip_busy", ip_busy, m_busy);
      check("busy_vec", busy_vec, ev);
      check("ip_timeout", ip_timeout, m_tmo);
      check("stall_cnt", stall_cnt, m_cnt);
      if (!RSTN) begin
        m_busy = 0; m_tmo = 0; age = 0; m_cnt = 0;
        foreach (pend[i]) pend[i] = 0;
      end else begin
        if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        if (e_start) begin
          m_busy = 1; age = 0; ld = dst_ID;
          if (RegWrite_ID && dst_ID != 0) pend[dst_ID] = 1;
        end else if (m_busy) begin
          if (ip_done) begin
            m_busy = 0; pend[ip_dst] = 0;
          end else if (age + 1 == TMO) begin
            m_busy = 0; m_tmo = 1;
            foreach (pend[i]) pend[i] = 0;
          end else age++;
        end
      end
      @(posedge CLK); #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer-side counterpart to the EX-stage forwarding unit. It tracks outstanding register writes that forwarding cannot cover: load results and results from the multi-cycle custom IP. When the ID-stage instruction depends on such a result, it stalls IF/ID and injects a bubble into EX. It sits between the ID/EX pipeline register and the custom IP interface, and also supplies a pending-write vector and a timeout watchdog.

Parameters:
NREG, 32, architectural register count; r0 is never tracked.
TIMEOUT, 64, cycles the custom IP may stay busy before the watchdog fires.
CNT_W, 16, width of the stall-cycle statistics counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTN  input  1  reset, synchronous, active-low.
src1_ID  input  5  ID source register 1.
src2_ID  input  5  ID source register 2.
use1_ID  input  1  src1_ID is actually read.
use2_ID  input  1  src2_ID is actually read.
dst_ID  input  5  ID destination register.
RegWrite_ID  input  1  ID instruction writes dst_ID.
LongOp_ID  input  1  ID instruction is a custom-IP operation.
valid_ID  input  1  ID holds a real instruction.
FLUSH  input  1  branch flush; kills the ID instruction this cycle.
dst_EX  input  5  EX destination register.
MemRead_EX  input  1  EX instruction is a load.
RegWrite_EX  input  1  EX instruction writes dst_EX.
ip_done  input  1  custom IP result is written back this cycle.
ip_dst  input  5  destination register of the completing IP result.
stall  output  1  hold PC and the IF/ID register.
bubble_EX  output  1  load a NOP into ID/EX.
ip_start  output  1  one-cycle launch pulse to the custom IP.
ip_busy  output  1  custom IP has an operation in flight.
busy_vec  output  NREG  pending long-op write per register; bit 0 is always 0.
ip_timeout  output  1  sticky watchdog flag.
stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (RSTN low at an edge): busy_vec=0, ip_busy=0, ip_timeout=0, stall_cnt=0, watchdog counter=0. Reset applied mid-operation discards the in-flight op; a later ip_done is ignored because ip_busy=0.
- Every busy/stall evaluation excludes register 0.
- Load-use hazard (combinational): MemRead_EX & RegWrite_EX & dst_EX≠0 & ((use1_ID & src1_ID==dst_EX) | (use2_ID & src2_ID==dst_EX)).
- Scoreboard hazard (combinational, from registered busy_vec): a used source, or dst_ID with RegWrite_ID (WAW), has its busy bit set.
- Structural hazard: LongOp_ID & ip_busy.
- stall = valid_ID & ~FLUSH & (any hazard). bubble_EX = stall | FLUSH.
- Issue occurs when valid_ID & ~FLUSH & ~stall. If an issuing instruction has LongOp_ID, then ip_start=1 that cycle. At the next edge: ip_busy←1, watchdog←0, and busy_vec[dst_ID]←1 if RegWrite_ID & dst_ID≠0.
- Completion: ip_done & ip_busy at an edge gives ip_busy←0 and busy_vec[ip_dst]←0. ip_done while ~ip_busy is ignored.
- No same-cycle bypass. A dependent instruction in ID during the ip_done cycle still stalls and issues the following cycle; its value then comes from the register file or WB forwarding. A new long op likewise cannot issue in the ip_done cycle. As a result, set and clear never collide.
- Watchdog: increments while ip_busy. When it reaches TIMEOUT-1 and ip_done is absent: ip_busy←0, busy_vec←0, ip_timeout←1 (sticky until reset).
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.
- Latency: load-use costs exactly 1 stall cycle. A long-op dependency stalls from issue+1 until the cycle after ip_done.

Test Plan:
1. Load r5, then add r6←r5,r1 in the next instruction: stall=1 and bubble_EX=1 for exactly 1 cycle, and stall_cnt=1. The same sequence with a load to r0 gives no stall.
2. Long op to r7 (ip_start pulse, busy_vec[7]=1), dependent reading r7, ip_done with ip_dst=7 four cycles later: stall held through the ip_done cycle, released the next cycle, busy_vec=0.
3. Long op to r3 followed by an independent add r4←r1,r2: no stall. A second long op while ip_busy: stall until the cycle after ip_done, then ip_start for the second op.
4. WAW: long op to r9 in flight, then a plain write to r9: stall until r9 is cleared.
5. TIMEOUT=8, long op with no ip_done: after 8 busy cycles, ip_busy=0, busy_vec=0, ip_timeout=1. A later spurious ip_done changes nothing.
6. Reset asserted while ip_busy=1 and busy_vec[2]=1: all outputs zero after the edge. FLUSH with a load-use hazard present gives stall=0, bubble_EX=1, and no busy bit set.
